button_press_ctrl: RTL

- Sequencing controller for a single push-button input.
- Synchronizes the raw asynchronous button through a 2-flop chain, then runs a debounce/classification FSM on the synchronized level.
- Classifies each press as short or long and emits auto-repeat pulses while a long press is held.
- Its registered 1-cycle pulses feed downstream counters and menu logic, replacing bare edge detection on the button.

---
 rtl/button_press_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/button_press_ctrl.sv
// Push-button controller: 2-flop synchronizer, debounce, short/long press
// classification and auto-repeat, all outputs registered.
module button_press_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned LONG_CYC     = 16,
  parameter int unsigned REPEAT_CYC   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic en,
  output logic pressed,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int unsigned MaxDl  = (DEBOUNCE_CYC > LONG_CYC) ? DEBOUNCE_CYC : LONG_CYC;
  localparam int unsigned MaxCyc = (MaxDl > REPEAT_CYC) ? MaxDl : REPEAT_CYC;
  // Counters only ever reach MaxCyc-1, so $clog2 bits suffice.
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0] DbLast   = CntW'(DEBOUNCE_CYC - 1);
  localparam logic [CntW-1:0] LongLast = CntW'(LONG_CYC - 1);
  localparam logic [CntW-1:0] RepLast  = CntW'(REPEAT_CYC - 1);
  localparam logic [CntW-1:0] CntZero  = '0;
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StDbPress,
    StHeld,
    StLongHeld,
    StDbRelease
  } state_e;

  state_e          state_q, state_d;
  logic            ff1_q, ff1_d;
  logic            ff2_q, ff2_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
  logic [CntW-1:0] rep_cnt_q, rep_cnt_d;
  logic            long_flag_q, long_flag_d;
  logic            pressed_q, pressed_d;
  logic            short_q, short_d;
  logic            long_q, long_d;
  logic            rep_pulse_q, rep_pulse_d;
  logic            btn_s;

  assign btn_s = ff2_q;

  always_comb begin
    ff1_d       = btn;
    ff2_d       = ff1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_cnt_d  = hold_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    long_flag_d = long_flag_q;
    pressed_d   = pressed_q;
    short_d     = 1'b0;
    long_d      = 1'b0;
    rep_pulse_d = 1'b0;

    if (!en) begin
      state_d     = StIdle;
      cnt_d       = CntZero;
      hold_cnt_d  = CntZero;
      rep_cnt_d   = CntZero;
      long_flag_d = 1'b0;
      pressed_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          pressed_d = 1'b0;
          if (btn_s) begin
            state_d = StDbPress;
            cnt_d   = CntOne;
          end
        end

        StDbPress: begin
          if (!btn_s) begin
            state_d = StIdle;
            cnt_d   = CntZero;
          end else if (cnt_q == DbLast) begin
            state_d    = StHeld;
            pressed_d  = 1'b1;
            hold_cnt_d = CntZero;
            cnt_d      = CntZero;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        StHeld: begin
          if (!btn_s) begin
            state_d     = StDbRelease;
            cnt_d       = CntOne;
            long_flag_d = 1'b0;
          end else if (hold_cnt_q == LongLast) begin
            state_d   = StLongHeld;
            long_d    = 1'b1;
            rep_cnt_d = CntZero;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end

        StLongHeld: begin
          if (!btn_s) begin
            state_d     = StDbRelease;
            cnt_d       = CntOne;
            long_flag_d = 1'b1;
          end else if (rep_cnt_q == RepLast) begin
            rep_pulse_d = 1'b1;
            rep_cnt_d   = CntZero;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end

        StDbRelease: begin
          // Hold/repeat counts stay frozen so a bounce resumes where it left off.
          if (btn_s) begin
            state_d = long_flag_q ? StLongHeld : StHeld;
            cnt_d   = CntZero;
          end else if (cnt_q == DbLast) begin
            state_d     = StIdle;
            pressed_d   = 1'b0;
            short_d     = ~long_flag_q;
            cnt_d       = CntZero;
            hold_cnt_d  = CntZero;
            rep_cnt_d   = CntZero;
            long_flag_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d   = StIdle;
          pressed_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ff1_q       <= 1'b0;
      ff2_q       <= 1'b0;
      cnt_q       <= CntZero;
      hold_cnt_q  <= CntZero;
      rep_cnt_q   <= CntZero;
      long_flag_q <= 1'b0;
      pressed_q   <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      rep_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ff1_q       <= ff1_d;
      ff2_q       <= ff2_d;
      cnt_q       <= cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      long_flag_q <= long_flag_d;
      pressed_q   <= pressed_d;
      short_q     <= short_d;
      long_q      <= long_d;
      rep_pulse_q <= rep_pulse_d;
    end
  end

  assign pressed      = pressed_q;
  assign short_press  = short_q;
  assign long_press   = long_q;
  assign repeat_pulse = rep_pulse_q;

endmodule
